// File: rtl/booth_r4_pkg.sv
// Shared types, state encodings and Booth window decode for the radix-4 sequential multiplier.
package booth_r4_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned ITER_COUNT    = DEFAULT_WIDTH / 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Window is {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
  localparam logic [2:0] BOOTH_POS_1A = 3'b001;
  localparam logic [2:0] BOOTH_POS_1B = 3'b010;
  localparam logic [2:0] BOOTH_POS_2  = 3'b011;
  localparam logic [2:0] BOOTH_NEG_2  = 3'b100;
  localparam logic [2:0] BOOTH_NEG_1A = 3'b101;
  localparam logic [2:0] BOOTH_NEG_1B = 3'b110;
  localparam logic [2:0] BOOTH_ZERO_N = 3'b111;

  typedef struct packed {
    logic zero;
    logic dbl;
    logic neg;
  } booth_ctrl_t;

  // neg follows the window MSB; for 111 the inverted zero plus carry-in still sums to zero
  function automatic booth_ctrl_t booth_decode(input logic [2:0] win);
    booth_ctrl_t ctrl;
    ctrl.zero = (win == BOOTH_ZERO_P) || (win == BOOTH_ZERO_N);
    ctrl.dbl  = (win == BOOTH_POS_2) || (win == BOOTH_NEG_2);
    ctrl.neg  = win[2];
    return ctrl;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth accumulation step: hi + {0, +-A, +-2A} over WIDTH+2 bits.
module booth_r4_step
  import booth_r4_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] hi,
  output logic [WIDTH+1:0] sum_c
);

  localparam int unsigned HI_W = WIDTH + 2;

  booth_ctrl_t     ctrl;
  logic [HI_W-1:0] pp_mag;
  logic [HI_W-1:0] pp;

  assign ctrl = booth_decode(window);

  always_comb begin
    pp_mag = '0;
    if (!ctrl.zero) begin
      pp_mag = ctrl.dbl ? {a[WIDTH-1], a, 1'b0} : {{2{a[WIDTH-1]}}, a};
    end
    pp    = ctrl.neg ? ~pp_mag : pp_mag;
    sum_c = hi + pp + HI_W'(ctrl.neg);
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth signed multiplier: valid/ready in, WIDTH/2 recode steps, valid/ready out.
module booth_r4_seq_mult
  import booth_r4_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     data1_i,
  input  logic [WIDTH-1:0]     data2_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int unsigned ITERS = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam int unsigned HI_W  = WIDTH + 2;
  localparam int unsigned ACC_W = HI_W + WIDTH;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     a_q;
  logic [HI_W-1:0]      hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 bm1_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 out_valid_q;
  logic                 in_ready_q;

  logic                 last_iter;
  logic [HI_W-1:0]      step_sum;
  logic signed [ACC_W-1:0] acc_sh;

  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  booth_r4_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a      (a_q),
    .window ({lo_q[1:0], bm1_q}),
    .hi     (hi_q),
    .sum_c  (step_sum)
  );

  // Arithmetic shift of {hi, multiplier} by one Booth digit
  assign acc_sh = $signed({step_sum, lo_q}) >>> 2;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_i)  state_d = ST_CALC;
      ST_CALC: if (last_iter)   state_d = ST_DONE;
      ST_DONE: if (out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags track the upcoming state so they are valid from the first cycle of each state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // Operand latch, accumulator, iteration counter and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      bm1_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_q   <= data1_i;
            lo_q  <= data2_i;
            hi_q  <= '0;
            bm1_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        ST_CALC: begin
          hi_q  <= acc_sh[ACC_W-1:WIDTH];
          lo_q  <= acc_sh[WIDTH-1:0];
          bm1_q <= lo_q[1];
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_q <= acc_sh[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult: stimulus queues expected products, monitor checks outputs.
module tb_booth_r4_seq_mult;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   data1;
  logic [W-1:0]   data2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic [15:0] exp_q[$];
  int          acc_q[$];

  booth_r4_seq_mult #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data1_i     (data1),
    .data2_i     (data2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold in_valid until it is accepted at the coming edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit push);
    int n = 0;
    tick();
    data1 = a;
    data2 = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept", 32'(in_ready), 1);
    if (in_ready) begin
      if (push) begin
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
      end
      last_acc = cyc;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 0);
  endtask

  // Monitor: latency on every rising out_valid, product on every output handshake
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) check("spurious_valid", 32'(out_valid), 0);
          else check("latency", 32'(cyc - acc_q[0]), 5);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(exp_q.size()), 1);
          end else begin
            check("product", 32'(result), 32'(exp_q.pop_front()));
            void'(acc_q.pop_front());
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  da[7];
    logic [7:0]  db[7];
    logic [15:0] dp[7];
    logic [7:0]  ba[3];
    logic [7:0]  bb[3];
    logic [15:0] bp[3];
    int          sv[12];
    int          prev_acc;
    int          n;

    da = '{8'd7,  8'h80, 8'h80, 8'd127, 8'd0,  8'hFB, 8'd2};
    db = '{8'd3,  8'h80, 8'd127, 8'hFF, 8'hB3, 8'd0,  8'hFD};
    dp = '{16'd21, 16'h4000, 16'hC080, 16'hFF81, 16'h0000, 16'h0000, 16'hFFFA};
    ba = '{8'd5,   8'hF3,    8'd100};
    bb = '{8'hFA,  8'd11,    8'd100};
    bp = '{16'hFFE2, 16'hFF71, 16'h2710};
    sv = '{-128, -127, -64, -1, 0, 1, 2, 3, 63, 64, 85, 127};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data1 = '0; data2 = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_result", 32'(result), 0);
    check("reset_in_ready", 32'(in_ready), 1);

    // 7*3 with in_ready low through all four CALC cycles
    send(da[0], db[0], dp[0], 1'b1);
    tick();
    in_valid = 1'b0;
    check("calc_in_ready", 32'(in_ready), 0);
    repeat (3) begin
      tick();
      check("calc_in_ready", 32'(in_ready), 0);
    end
    wait_drain();

    for (int i = 1; i < 7; i++) begin
      send(da[i], db[i], dp[i], 1'b1);
      tick();
      in_valid = 1'b0;
      wait_drain();
    end

    // Back-pressure with ignored in_valid pulses in DONE
    out_ready = 1'b0;
    send(8'h80, 8'd127, 16'hC080, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_result", 32'(result), 32'h0000C080);
      check("bp_in_ready", 32'(in_ready), 0);
      in_valid = i[0];
      data1 = 8'd3;
      data2 = 8'd3;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", 32'(in_ready), 1);
    check("bp_release_valid", 32'(out_valid), 0);
    check("result_hold_idle", 32'(result), 32'h0000C080);
    wait_drain();

    // Reset on the second CALC cycle discards 9*9
    send(8'd9, 8'd9, 16'd81, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_result", 32'(result), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    send(8'd2, 8'hFD, 16'hFFFA, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back with in_valid held high
    prev_acc = 0;
    for (int k = 0; k < 3; k++) begin
      send(ba[k], bb[k], bp[k], 1'b1);
      if (k > 0) check("b2b_spacing", 32'(last_acc - prev_acc), 6);
      prev_acc = last_acc;
    end
    tick();
    in_valid = 1'b0;
    wait_drain();

    // Corner-value cross product against a signed reference
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 12; j++) begin
        send(8'(sv[i]), 8'(sv[j]), 16'(sv[i] * sv[j]), 1'b1);
      end
    end
    tick();
    in_valid = 1'b0;
    wait_drain();

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
